nes_clk_enable_gen: RTL
=======================

Name: nes_clk_enable_gen

Overview:
- Consumes the 21.428 MHz PPU master clock from the PLL.
- Generates single-cycle clock enables for the PPU dot clock (÷4, 5.357 MHz) and the 6502 core (÷12, 1.786 MHz), plus an M2 phase level.
- Sequences system reset out of PLL lock.
- Provides run/halt/single-step control so the debug logic can freeze the CPU and PPU on a CPU-cycle boundary.

Parameters:
- CPU_DIV, 12, master cycles per CPU cycle; must be an integer multiple of PPU_DIV and at least 2.
- PPU_DIV, 4, master cycles per PPU dot.
- RST_HOLD, 16, master cycles rst_out stays high after lock is stable; at least 1.
- CYC_W, 16, width of the CPU cycle counter.

Ports:
- clk  in  1  master clock, 21.428 MHz PLL output.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indication, synchronous to clk; tie high if unused.
- run  in  1  level; 1 = free-run, 0 = halt at the next CPU-cycle boundary.
- step_req  in  1  single-cycle pulse; requests one CPU cycle while halted.
- rst_out  out  1  synchronous reset to CPU/PPU/VGA domains, active-high.
- ppu_ce  out  1  one-clk PPU dot enable.
- cpu_ce  out  1  one-clk CPU enable; always coincides with a ppu_ce.
- m2  out  1  CPU M2 phase level.
- halted  out  1  1 while in HALT state.
- step_done  out  1  one-clk pulse when a requested step completes.
- cpu_cycles  out  CYC_W  count of cpu_ce pulses since rst_out fell; wraps.

Behaviour:
- Reset is asynchronous and active-high. One clock domain only.
- Reset values:
  - rst_out=1; ppu_ce=0; cpu_ce=0; m2=0; halted=0; step_done=0; cpu_cycles=0.
  - Internal cnt=0, hold=0, state=RST_HOLD.
- All outputs are registered.
- States: RST_HOLD, RUN, HALT, STEP.
- RST_HOLD:
  - rst_out=1; cnt frozen at 0; no enables.
  - hold increments while pll_locked=1 and clears to 0 while pll_locked=0.
  - On the edge where hold==RST_HOLD-1 and pll_locked=1: rst_out<=0, then go to RUN if run=1, else HALT.
  - With RST_HOLD=16, rst_out falls 16 clks after the first locked cycle.
- Advancing cycle = state is RUN or STEP. On each advancing edge:
  - cnt <= (cnt==CPU_DIV-1) ? 0 : cnt+1.
  - ppu_ce <= (cnt mod PPU_DIV == PPU_DIV-1).
  - cpu_ce <= (cnt==CPU_DIV-1).
  - m2 <= (next cnt >= CPU_DIV/2).
  - cpu_cycles increments on each cpu_ce and wraps at 2^CYC_W.
- Net effect: ppu_ce is high while cnt ∈ {0,4,8}, cpu_ce while cnt=0. After entering RUN at cnt=0, the first ppu_ce occurs 4 clks later and the first cpu_ce 12 clks later.
- Non-advancing cycle: ppu_ce<=0, cpu_ce<=0; cnt and m2 hold.
- RUN:
  - If run=0, transition to HALT on the edge where cnt==CPU_DIV-1; that final cpu_ce is still issued.
  - Halt therefore always rests at cnt=0.
- HALT:
  - halted=1.
  - run=1 → RUN next clk.
  - Otherwise step_req=1 → STEP.
  - step_req and run both 1 → RUN; step_req is dropped.
- STEP:
  - Advances exactly CPU_DIV clks, producing CPU_DIV/PPU_DIV ppu_ce and exactly one cpu_ce.
  - On the edge where cnt==CPU_DIV-1: step_done<=1 coincident with cpu_ce, then go to RUN if run=1, else HALT.
  - step_req during STEP or RUN is ignored; it is not queued.
- pll_locked=0 in any state:
  - Next edge: state=RST_HOLD, rst_out=1, cnt=0, hold=0, ppu_ce=cpu_ce=m2=0, halted=0, step_done=0, cpu_cycles=0.
- Asynchronous rst mid-operation forces all reset values immediately.

Test Plan:
- Reset, then pll_locked=1 and run=1 → rst_out falls exactly 16 clks after lock; ppu_ce pulses every 4 clks; cpu_ce every 12 clks, aligned with every third ppu_ce; m2 high for 6 of 12 clks.
- pll_locked toggles 1,0,1 with 10 clks high in between → hold restarts; rst_out falls 16 clks after the final rise.
- Run 100 CPU cycles, then drop run while cnt=5 → 7 more clks, final cpu_ce, halted=1; cpu_cycles=101; no enables while halted.
- While halted, pulse step_req → exactly 3 ppu_ce and 1 cpu_ce; step_done coincides with cpu_ce; halted re-asserts; cpu_cycles +1.
- step_req asserted during STEP, and step_req with run=1 in HALT → no extra step; RUN resumes with cnt=0 alignment.
- Drop pll_locked mid-run at cnt=7 → next clk: rst_out=1, enables 0, cpu_cycles=0. Assert async rst mid-STEP → outputs reset without waiting for clk.

Source files
------------

// File: rtl/nes_clk_enable_gen.sv
// Master-clock enable generator for the NES core: PPU dot and CPU enables, M2 phase,
// PLL-lock reset sequencing, and run/halt/single-step control on CPU-cycle boundaries.
module nes_clk_enable_gen #(
   parameter int unsigned CpuDiv  = 12,
   parameter int unsigned PpuDiv  = 4,
   parameter int unsigned RstHold = 16,
   parameter int unsigned CycW    = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            pll_locked_i,
   input  logic            run_i,
   input  logic            step_req_i,
   output logic            rst_out_o,
   output logic            ppu_ce_o,
   output logic            cpu_ce_o,
   output logic            m2_o,
   output logic            halted_o,
   output logic            step_done_o,
   output logic [CycW-1:0] cpu_cycles_o
);

   localparam int unsigned CntW  = (CpuDiv > 1) ? $clog2(CpuDiv) : 1;
   localparam int unsigned HoldW = $clog2(RstHold + 1);

   localparam logic [CntW-1:0]  CntLast  = CntW'(CpuDiv - 1);
   localparam logic [CntW-1:0]  CntHalf  = CntW'(CpuDiv / 2);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHold - 1);

   typedef enum logic [1:0] {
      StRstHold,
      StRun,
      StHalt,
      StStep
   } state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             rst_out_q, rst_out_d;
   logic             ppu_ce_q, ppu_ce_d;
   logic             cpu_ce_q, cpu_ce_d;
   logic             m2_q, m2_d;
   logic             halted_q, halted_d;
   logic             step_done_q, step_done_d;
   logic [CycW-1:0]  cpu_cycles_q, cpu_cycles_d;

   logic advance;
   logic at_last;
   logic ppu_hit;

   assign at_last = (cnt_q == CntLast);
   // Dot enable fires on the last master cycle of each dot so it lands on cnt 0, 4, 8 ...
   assign ppu_hit = ((32'(cnt_q) % PpuDiv) == (PpuDiv - 1));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      hold_d       = hold_q;
      rst_out_d    = rst_out_q;
      ppu_ce_d     = 1'b0;
      cpu_ce_d     = 1'b0;
      m2_d         = m2_q;
      halted_d     = 1'b0;
      step_done_d  = 1'b0;
      cpu_cycles_d = cpu_cycles_q;
      advance      = 1'b0;

      if (!pll_locked_i) begin
         state_d      = StRstHold;
         rst_out_d    = 1'b1;
         cnt_d        = '0;
         hold_d       = '0;
         m2_d         = 1'b0;
         cpu_cycles_d = '0;
      end else begin
         unique case (state_q)
            StRstHold: begin
               rst_out_d = 1'b1;
               if (hold_q == HoldLast) begin
                  rst_out_d = 1'b0;
                  hold_d    = '0;
                  state_d   = run_i ? StRun : StHalt;
               end else begin
                  hold_d = hold_q + 1'b1;
               end
            end
            StRun: begin
               advance = 1'b1;
               if (at_last && !run_i) begin
                  state_d = StHalt;
               end
            end
            StHalt: begin
               // run wins over a simultaneous step request; the request is dropped
               if (run_i) begin
                  state_d = StRun;
               end else if (step_req_i) begin
                  state_d = StStep;
               end
            end
            StStep: begin
               advance = 1'b1;
               if (at_last) begin
                  step_done_d = 1'b1;
                  state_d     = run_i ? StRun : StHalt;
               end
            end
         endcase

         if (advance) begin
            cnt_d    = at_last ? '0 : cnt_q + 1'b1;
            ppu_ce_d = ppu_hit;
            cpu_ce_d = at_last;
            m2_d     = (cnt_d >= CntHalf);
            if (at_last) begin
               cpu_cycles_d = cpu_cycles_q + 1'b1;
            end
         end

         halted_d = (state_d == StHalt);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StRstHold;
         cnt_q        <= '0;
         hold_q       <= '0;
         rst_out_q    <= 1'b1;
         ppu_ce_q     <= 1'b0;
         cpu_ce_q     <= 1'b0;
         m2_q         <= 1'b0;
         halted_q     <= 1'b0;
         step_done_q  <= 1'b0;
         cpu_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         hold_q       <= hold_d;
         rst_out_q    <= rst_out_d;
         ppu_ce_q     <= ppu_ce_d;
         cpu_ce_q     <= cpu_ce_d;
         m2_q         <= m2_d;
         halted_q     <= halted_d;
         step_done_q  <= step_done_d;
         cpu_cycles_q <= cpu_cycles_d;
      end
   end

   assign rst_out_o    = rst_out_q;
   assign ppu_ce_o     = ppu_ce_q;
   assign cpu_ce_o     = cpu_ce_q;
   assign m2_o         = m2_q;
   assign halted_o     = halted_q;
   assign step_done_o  = step_done_q;
   assign cpu_cycles_o = cpu_cycles_q;

endmodule
